// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pkg: shared constants and FSM state type for the instruction-fetch stage.
package fetch_pkg;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [4:0]  OPC_BRANCH    = 5'b11000;
    typedef enum logic [1:0] {RUN, STALL, STALL_PEND} state_t;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: predictor/hazard inputs, imem port and IF/ID outputs of the fetch stage.
interface fetch_pc_unit_if;
    logic        stall_i;
    logic        pc_control_i;
    logic [31:0] pc_address_i;
    logic        flush_control_i;
    logic [31:0] instr_i;
    logic [31:0] imem_addr_o;
    logic [31:0] pc_o;
    logic [4:0]  opcode_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
    logic [15:0] flush_cnt_o;
    modport master (
        output stall_i, pc_control_i, pc_address_i, flush_control_i, instr_i,
        input  imem_addr_o, pc_o, opcode_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, flush_cnt_o
    );
    modport slave (
        input  stall_i, pc_control_i, pc_address_i, flush_control_i, instr_i,
        output imem_addr_o, pc_o, opcode_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, flush_cnt_o
    );
endinterface

// File: rtl/fetch_pc_unit_ifid_reg.sv
// ifid_reg: IF/ID pipeline register; flush inserts a bubble and wins over load.
module ifid_reg import fetch_pkg::*; #(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid
);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (flush) begin
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (load) begin
            ifid_pc    <= pc;
            ifid_instr <= instr;
            ifid_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter, redirect handling with a one-entry pending buffer
// for redirects seen during a stall, and the IF/ID register.
module fetch_pc_unit import fetch_pkg::*; #(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input logic           clk_i,
    input logic           rst_ni,
    fetch_pc_unit_if.slave bus
);
    state_t      state, state_next;
    logic [31:0] pc, pc_next, pend_addr, pend_addr_next;
    logic        pend_flush, pend_flush_next;
    logic [15:0] flush_cnt;
    logic        ifid_load, ifid_flush;
    logic        pend;

    assign pend = state == STALL_PEND;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= RUN;
        else         state <= state_next;
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        pend_addr_next  = pend_addr;
        pend_flush_next = pend_flush;
        ifid_load       = 1'b0;
        ifid_flush      = bus.flush_control_i;
        if (!bus.stall_i) begin
            pc_next         = bus.pc_control_i ? bus.pc_address_i : pend ? pend_addr : pc + 32'd4;
            ifid_flush      = bus.flush_control_i | (pend & pend_flush);
            ifid_load       = 1'b1;
            pend_addr_next  = '0;
            pend_flush_next = 1'b0;
            state_next      = RUN;
        end else if (pend) begin
            pend_addr_next  = bus.pc_control_i ? bus.pc_address_i : pend_addr;
            pend_flush_next = pend_flush | bus.flush_control_i;
        end else begin
            // a redirect during a stall is buffered so it is never lost
            state_next      = bus.pc_control_i ? STALL_PEND : STALL;
            pend_addr_next  = bus.pc_control_i ? bus.pc_address_i : pend_addr;
            pend_flush_next = bus.pc_control_i ? bus.flush_control_i : pend_flush;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc         <= RESET_PC;
            pend_addr  <= '0;
            pend_flush <= 1'b0;
            flush_cnt  <= '0;
        end else begin
            pc         <= pc_next;
            pend_addr  <= pend_addr_next;
            pend_flush <= pend_flush_next;
            if (bus.flush_control_i && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
    end

    ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load       (ifid_load),
        .flush      (ifid_flush),
        .pc         (pc),
        .instr      (bus.instr_i),
        .ifid_pc    (bus.ifid_pc_o),
        .ifid_instr (bus.ifid_instr_o),
        .ifid_valid (bus.ifid_valid_o)
    );

    assign bus.imem_addr_o = pc;
    assign bus.pc_o        = pc;
    assign bus.opcode_o    = bus.instr_i[6:2];
    assign bus.flush_cnt_o = flush_cnt;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed vector table plus hand sequences for async reset and counter saturation.
module tb_fetch_pc_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fetch_pc_unit_if bus();
    fetch_pc_unit dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        pcc;
        logic [31:0] addr;
        logic        flush;
        logic [31:0] instr;
        logic [4:0]  op;
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] iinstr;
        logic        v;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                             input logic [31:0] iinstr, input logic v, input logic [15:0] cnt);
        chk({tag, " pc"}, bus.pc_o, pc);
        chk({tag, " imem_addr"}, bus.imem_addr_o, pc);
        chk({tag, " ifid_pc"}, bus.ifid_pc_o, ipc);
        chk({tag, " ifid_instr"}, bus.ifid_instr_o, iinstr);
        chk({tag, " ifid_valid"}, {31'd0, bus.ifid_valid_o}, {31'd0, v});
        chk({tag, " flush_cnt"}, {16'd0, bus.flush_cnt_o}, {16'd0, cnt});
    endtask

    task automatic drive(input logic stall, input logic pcc, input logic [31:0] addr,
                         input logic flush, input logic [31:0] instr);
        bus.stall_i = stall;
        bus.pc_control_i = pcc;
        bus.pc_address_i = addr;
        bus.flush_control_i = flush;
        bus.instr_i = instr;
    endtask

    initial begin
        //              stall pcc addr           flush instr          op     pc             ifid_pc        ifid_instr     v     cnt
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0063, 5'h18, 32'h4,        32'h0,        32'h0000_0063, 1'b1, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0010_0093, 5'h04, 32'h8,        32'h4,        32'h0010_0093, 1'b1, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 32'h40,       1'b0, 32'h0000_0463, 5'h18, 32'h40,       32'h8,        32'h0000_0463, 1'b1, 16'd0};
        vecs[3]  = '{1'b0, 1'b1, 32'hC,        1'b1, 32'h0000_006F, 5'h1B, 32'hC,        32'h0,        32'h0000_0013, 1'b0, 16'd1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_2003, 5'h00, 32'h10,       32'hC,        32'h0000_2003, 1'b1, 16'd1};
        vecs[5]  = '{1'b1, 1'b1, 32'h80,       1'b1, 32'h0000_0013, 5'h04, 32'h10,       32'h0,        32'h0000_0013, 1'b0, 16'd2};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0037, 5'h0D, 32'h10,       32'h0,        32'h0000_0013, 1'b0, 16'd2};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0033, 5'h0C, 32'h10,       32'h0,        32'h0000_0013, 1'b0, 16'd2};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0067, 5'h19, 32'h80,       32'h0,        32'h0000_0013, 1'b0, 16'd2};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0023, 5'h08, 32'h84,       32'h80,       32'h0000_0023, 1'b1, 16'd2};
        vecs[10] = '{1'b1, 1'b1, 32'h80,       1'b0, 32'h0000_0063, 5'h18, 32'h84,       32'h80,       32'h0000_0023, 1'b1, 16'd2};
        vecs[11] = '{1'b0, 1'b1, 32'h100,      1'b0, 32'h0000_0017, 5'h05, 32'h100,      32'h84,       32'h0000_0017, 1'b1, 16'd2};
        vecs[12] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0073, 5'h1C, 32'h100,      32'h84,       32'h0000_0017, 1'b1, 16'd2};
        vecs[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_000F, 5'h03, 32'h100,      32'h0,        32'h0000_0013, 1'b0, 16'd3};
        vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h1234_5093, 5'h04, 32'h104,      32'h100,      32'h1234_5093, 1'b1, 16'd3};
        vecs[15] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hDEAD_B0B7, 5'h0D, 32'hFFFF_FFFC, 32'h104,     32'hDEAD_B0B7, 1'b1, 16'd3};
        vecs[16] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'hCAFE_0063, 5'h18, 32'h0,        32'hFFFF_FFFC, 32'hCAFE_0063, 1'b1, 16'd3};
        vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h00C5_8533, 5'h0C, 32'h4,        32'h0,        32'h00C5_8533, 1'b1, 16'd3};

        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1 chk_state("reset", 32'h0, 32'h0, 32'h13, 1'b0, 16'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge clk);
            drive(vecs[i].stall, vecs[i].pcc, vecs[i].addr, vecs[i].flush, vecs[i].instr);
            #1 chk($sformatf("v%0d opcode", i), {27'd0, bus.opcode_o}, {27'd0, vecs[i].op});
            @(posedge clk);
            #1 chk_state($sformatf("v%0d", i), vecs[i].pc, vecs[i].ipc, vecs[i].iinstr, vecs[i].v, vecs[i].cnt);
        end

        // buffer a redirect, then hit async reset mid-cycle while in STALL_PEND
        @(negedge clk) drive(1'b1, 1'b1, 32'h200, 1'b1, 32'h0000_0013);
        @(posedge clk);
        #1 chk("pend pc hold", bus.pc_o, 32'h4);
        @(negedge clk) drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0000_0013);
        #2 rst_n = 1'b0;
        #1 chk_state("async rst", 32'h0, 32'h0, 32'h13, 1'b0, 16'd0);
        @(negedge clk) rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0093);
        @(posedge clk);
        #1 chk_state("post rst", 32'h4, 32'h0, 32'h0000_0093, 1'b1, 16'd0);

        // saturate the flush counter while stalled
        @(negedge clk) drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0013);
        repeat (65534) @(posedge clk);
        #1 chk("cnt preload", {16'd0, bus.flush_cnt_o}, 32'h0000_FFFE);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 chk($sformatf("sat %0d", k), {16'd0, bus.flush_cnt_o}, 32'h0000_FFFF);
        end
        chk("sat pc hold", bus.pc_o, 32'h4);
        @(negedge clk) drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0013);
        @(posedge clk);
        #1 chk_state("sat release", 32'h8, 32'h4, 32'h0000_0013, 1'b1, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
